// File: rtl/fetch_unit_if.sv
// Fetch unit bus interface.
// Bundles the rom port and the decode-side valid/ready port of the fetch stage.
//   fetch_en       : issue enable
//   rom_address    : address driven to the synchronous rom
//   rom_data       : rom word, valid one cycle after the address is sampled
//   branch_valid   : one-cycle redirect request
//   branch_target  : redirect target PC
//   instr_valid    : fetched word available to decode
//   instr_ready    : decode accepts when instr_valid & instr_ready
//   instr          : fetched instruction word
//   instr_pc       : address the word was fetched from
// Modports: master = fetch unit side, slave = rom/decode/control side.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] rom_address;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  branch_valid;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        input  fetch_en, rom_data, branch_valid, branch_target, instr_ready,
        output rom_address, instr_valid, instr, instr_pc
    );

    modport slave (
        output fetch_en, rom_data, branch_valid, branch_target, instr_ready,
        input  rom_address, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a 1-cycle synchronous rom.
// Holds the PC, issues one rom read per cycle, captures the returned word and
// hands it to decode over valid/ready. A single-entry skid buffer absorbs the
// word that is already in flight when decode stalls, so no word is lost.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : fetch_unit_if.master (rom port, redirect, decode handshake)
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 8'h00
) (
    input  logic          clock,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] req_pc_r;
    logic                  inflight_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_instr_r;
    logic [ADDR_WIDTH-1:0] out_pc_r;
    logic                  skid_valid_r;
    logic [DATA_WIDTH-1:0] skid_instr_r;
    logic [ADDR_WIDTH-1:0] skid_pc_r;

    logic issue_s;
    logic accept_s;

    // Decode consumes the output word this cycle.
    assign accept_s = out_valid_r & bus.instr_ready;

    // Stop issuing once the in-flight word would need the skid while it is
    // already claimed; this bounds outstanding words to output + skid.
    assign issue_s = bus.fetch_en & ~skid_valid_r
                   & ~(out_valid_r & ~bus.instr_ready & inflight_r)
                   & ~bus.branch_valid;

    assign bus.rom_address = pc_r;
    assign bus.instr_valid = out_valid_r;
    assign bus.instr       = out_instr_r;
    assign bus.instr_pc    = out_pc_r;

    // PC, in-flight tracking, output/skid registers and control FSM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            req_pc_r     <= '0;
            inflight_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_instr_r  <= '0;
            out_pc_r     <= '0;
            skid_valid_r <= 1'b0;
            skid_instr_r <= '0;
            skid_pc_r    <= '0;
        end else if (bus.branch_valid) begin
            // Redirect wins; any same-cycle handshake has already consumed
            // the output word, so flushing valid loses nothing accepted.
            pc_r         <= bus.branch_target;
            inflight_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            out_valid_r  <= 1'b0;
            state_r      <= RUN;
        end else begin
            if (issue_s) begin
                pc_r     <= pc_r + PC_ONE;
                req_pc_r <= pc_r;
            end
            inflight_r <= issue_s;

            if (accept_s) begin
                // Skid holds the older word, so it always drains first.
                if (skid_valid_r) begin
                    out_instr_r  <= skid_instr_r;
                    out_pc_r     <= skid_pc_r;
                    skid_valid_r <= 1'b0;
                end else if (inflight_r) begin
                    out_instr_r <= bus.rom_data;
                    out_pc_r    <= req_pc_r;
                end else begin
                    out_valid_r <= 1'b0;
                end
            end else if (inflight_r) begin
                if (!out_valid_r) begin
                    out_instr_r <= bus.rom_data;
                    out_pc_r    <= req_pc_r;
                    out_valid_r <= 1'b1;
                end else begin
                    skid_instr_r <= bus.rom_data;
                    skid_pc_r    <= req_pc_r;
                    skid_valid_r <= 1'b1;
                end
            end

            case (state_r)
                IDLE: begin
                    if (issue_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (!bus.fetch_en && !inflight_r && !skid_valid_r) begin
                        state_r <= IDLE;
                    end else if (inflight_r && out_valid_r && !bus.instr_ready) begin
                        state_r <= STALL;
                    end else begin
                        state_r <= RUN;
                    end
                end
                STALL: begin
                    if (accept_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= STALL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle rom model
// returning {8'hA5, addr}. Outputs are sampled 1 time unit after the edge.
module tb_fetch_unit;

    logic clock;
    logic reset_n;
    int   vectors;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous rom model.
    always @(posedge clock) bus.rom_data <= {8'hA5, bus.rom_address};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        bus.fetch_en      = 1'b0;
        bus.instr_ready   = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        repeat (3) tick();
        vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.instr_valid); end
        vectors++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", bus.instr); end
        vectors++; if (bus.instr_pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", bus.instr_pc); end
        vectors++; if (bus.rom_address !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", bus.rom_address); end
    endtask

    task automatic test_stream();
        bus.fetch_en    = 1'b1;
        bus.instr_ready = 1'b1;
        reset_n         = 1'b1;
        tick();
        vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_lat1: valid got %0b want 0", bus.instr_valid); end
        vectors++; if (bus.rom_address !== 8'h01) begin errors++; $display("FAIL stream_addr1: got %h want 01", bus.rom_address); end
        tick();
        vectors++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stream_lat2: valid got %0b want 1", bus.instr_valid); end
        vectors++; if (bus.instr !== 16'hA500) begin errors++; $display("FAIL stream_first: got %h want A500", bus.instr); end
        vectors++; if (bus.instr_pc !== 8'h00) begin errors++; $display("FAIL stream_first_pc: got %h want 00", bus.instr_pc); end
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] e;
            e = i[7:0];
            tick();
            vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== {8'hA5, e} || bus.instr_pc !== e) begin
                errors++; $display("FAIL stream_seq: got v=%0b %h@%h want v=1 %h@%h", bus.instr_valid, bus.instr, bus.instr_pc, {8'hA5, e}, e);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] e;
        int         got;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA505 || bus.instr_pc !== 8'h05) begin
                errors++; $display("FAIL stall_hold: got v=%0b %h@%h want v=1 A505@05", bus.instr_valid, bus.instr, bus.instr_pc);
            end
        end
        bus.instr_ready = 1'b1;
        e   = 8'h05;
        got = 0;
        for (int c = 0; c < 20 && got < 3; c++) begin
            if (bus.instr_valid === 1'b1) begin
                vectors++; if (bus.instr !== {8'hA5, e} || bus.instr_pc !== e) begin
                    errors++; $display("FAIL stall_drain: got %h@%h want %h@%h", bus.instr, bus.instr_pc, {8'hA5, e}, e);
                end
                e++;
                got++;
            end
            tick();
        end
        vectors++; if (got != 3) begin errors++; $display("FAIL stall_timeout: got %0d words want 3", got); end
    endtask

    task automatic test_branch();
        logic [7:0] e;
        logic       found;
        e     = 8'h08;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.instr_valid === 1'b1) begin
                vectors++; if (bus.instr !== {8'hA5, e} || bus.instr_pc !== e) begin
                    errors++; $display("FAIL branch_pre: got %h@%h want %h@%h", bus.instr, bus.instr_pc, {8'hA5, e}, e);
                end
                if (e == 8'h10) begin
                    found = 1'b1;
                    break;
                end
                e++;
            end
            tick();
        end
        vectors++; if (found !== 1'b1) begin errors++; $display("FAIL branch_timeout: 0x10 seen %0b want 1", found); end
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'h40;
        tick();
        bus.branch_valid  = 1'b0;
        vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL branch_flush: valid got %0b want 0", bus.instr_valid); end
        vectors++; if (bus.rom_address !== 8'h40) begin errors++; $display("FAIL branch_addr: got %h want 40", bus.rom_address); end
        tick();
        vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL branch_gap: valid got %0b (%h@%h) want 0", bus.instr_valid, bus.instr, bus.instr_pc); end
        tick();
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA540 || bus.instr_pc !== 8'h40) begin
            errors++; $display("FAIL branch_target: got v=%0b %h@%h want v=1 A540@40", bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        int         got;
        bus.branch_valid  = 1'b1;
        bus.branch_target = 8'hFE;
        tick();
        bus.branch_valid  = 1'b0;
        e   = 8'hFE;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (bus.instr_valid === 1'b1) begin
                vectors++; if (bus.instr !== {8'hA5, e} || bus.instr_pc !== e) begin
                    errors++; $display("FAIL wrap_seq: got %h@%h want %h@%h", bus.instr, bus.instr_pc, {8'hA5, e}, e);
                end
                e++;
                got++;
            end
            tick();
        end
        vectors++; if (got != 4) begin errors++; $display("FAIL wrap_timeout: got %0d words want 4", got); end
    endtask

    task automatic test_fetch_en();
        // Entry: 0x02 in output, 0x03 in flight, pc 0x04.
        bus.fetch_en = 1'b0;
        tick();
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA503 || bus.instr_pc !== 8'h03) begin
            errors++; $display("FAIL fen_inflight: got v=%0b %h@%h want v=1 A503@03", bus.instr_valid, bus.instr, bus.instr_pc);
        end
        vectors++; if (bus.rom_address !== 8'h04) begin errors++; $display("FAIL fen_pc0: got %h want 04", bus.rom_address); end
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL fen_noissue: valid got %0b want 0", bus.instr_valid); end
            vectors++; if (bus.rom_address !== 8'h04) begin errors++; $display("FAIL fen_frozen: got %h want 04", bus.rom_address); end
        end
        bus.fetch_en = 1'b1;
        tick();
        vectors++; if (bus.rom_address !== 8'h05) begin errors++; $display("FAIL fen_resume_addr: got %h want 05", bus.rom_address); end
        tick();
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA504 || bus.instr_pc !== 8'h04) begin
            errors++; $display("FAIL fen_resume: got v=%0b %h@%h want v=1 A504@04", bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_reset_stall();
        bus.instr_ready = 1'b0;
        tick();
        tick();
        vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== 16'hA504) begin
            errors++; $display("FAIL rst_pre: got v=%0b %h want v=1 A504", bus.instr_valid, bus.instr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %0b want 0", bus.instr_valid); end
        vectors++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL rst_async_instr: got %h want 0000", bus.instr); end
        vectors++; if (bus.instr_pc !== 8'h00) begin errors++; $display("FAIL rst_async_pc: got %h want 00", bus.instr_pc); end
        vectors++; if (bus.rom_address !== 8'h00) begin errors++; $display("FAIL rst_async_addr: got %h want 00", bus.rom_address); end
        tick();
        reset_n         = 1'b1;
        bus.instr_ready = 1'b1;
        bus.fetch_en    = 1'b1;
        tick();
        vectors++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_restart_lat: valid got %0b want 0", bus.instr_valid); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e;
            e = i[7:0];
            tick();
            vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== {8'hA5, e} || bus.instr_pc !== e) begin
                errors++; $display("FAIL rst_restart_seq: got v=%0b %h@%h want v=1 %h@%h", bus.instr_valid, bus.instr, bus.instr_pc, {8'hA5, e}, e);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_wrap();
        test_fetch_en();
        test_reset_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
